// File: rtl/branch_target_buffer.sv
// Direct-mapped fetch-stage branch target buffer with a 1-cycle registered lookup and EX-stage training.
// Optional macro BTB_BYPASS_EN forwards a same-cycle, same-index update into the lookup response.
module branch_target_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_lookup_valid,
    input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
    output logic                  o_resp_valid,
    output logic                  o_hit,
    output logic                  o_pred_taken,
    output logic [ADDR_WIDTH-1:0] o_pred_target,
    input  logic                  i_update_valid,
    input  logic [ADDR_WIDTH-1:0] i_update_pc,
    input  logic [ADDR_WIDTH-1:0] i_update_target,
    input  logic                  i_update_outcome,
    input  logic                  i_update_is_jump,
    input  logic                  i_flush
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [1:0] CTR_SN = 2'd0;
    localparam logic [1:0] CTR_WT = 2'd2;
    localparam logic [1:0] CTR_ST = 2'd3;

    // Handshake: a lookup has no backpressure; each cycle with i_lookup_valid=1 yields
    // exactly one o_resp_valid=1 cycle on the next edge, and idle cycles yield all-zero outputs.

    logic [ENTRIES-1:0]    r_valid;
    logic [ENTRIES-1:0]    r_jmp;
    logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
    logic [1:0]            r_ctr    [ENTRIES];

    logic                  r_resp_valid;
    logic                  r_hit;
    logic                  r_pred_taken;
    logic [ADDR_WIDTH-1:0] r_pred_target;

    logic [INDEX_BITS-1:0] w_l_idx;
    logic [TAG_BITS-1:0]   w_l_tag;
    logic [INDEX_BITS-1:0] w_u_idx;
    logic [TAG_BITS-1:0]   w_u_tag;
    logic                  w_u_hit;

    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_new_target;
    logic [1:0]            w_new_ctr;
    logic                  w_new_jmp;

    logic                  w_rd_valid;
    logic [TAG_BITS-1:0]   w_rd_tag;
    logic [ADDR_WIDTH-1:0] w_rd_target;
    logic [1:0]            w_rd_ctr;
    logic                  w_l_hit;

    assign w_l_idx = i_lookup_pc[INDEX_BITS+1:2];
    assign w_l_tag = i_lookup_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign w_u_idx = i_update_pc[INDEX_BITS+1:2];
    assign w_u_tag = i_update_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    // Next entry contents for the update index; flush suppresses the write entirely.
    always_comb begin
        w_wr_en      = 1'b0;
        w_new_target = r_target[w_u_idx];
        w_new_ctr    = r_ctr[w_u_idx];
        w_new_jmp    = r_jmp[w_u_idx];
        if (i_update_valid && !i_flush) begin
            if (w_u_hit) begin
                w_wr_en = 1'b1;
                if (i_update_is_jump) begin
                    w_new_jmp    = 1'b1;
                    w_new_ctr    = CTR_ST;
                    w_new_target = i_update_target;
                end else if (r_jmp[w_u_idx]) begin
                    if (i_update_outcome) w_new_target = i_update_target;
                end else if (i_update_outcome) begin
                    if (r_ctr[w_u_idx] != CTR_ST) w_new_ctr = r_ctr[w_u_idx] + 2'd1;
                    w_new_target = i_update_target;
                end else begin
                    if (r_ctr[w_u_idx] != CTR_SN) w_new_ctr = r_ctr[w_u_idx] - 2'd1;
                end
            end else if (i_update_outcome || i_update_is_jump) begin
                w_wr_en      = 1'b1;
                w_new_target = i_update_target;
                w_new_ctr    = i_update_is_jump ? CTR_ST : CTR_WT;
                w_new_jmp    = i_update_is_jump;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (w_wr_en) begin
            r_valid[w_u_idx] <= 1'b1;
        end
    end

    // Payload fields are meaningless while the entry is invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= w_new_target;
            r_ctr[w_u_idx]    <= w_new_ctr;
            r_jmp[w_u_idx]    <= w_new_jmp;
        end
    end

    always_comb begin
        w_rd_valid  = r_valid[w_l_idx];
        w_rd_tag    = r_tag[w_l_idx];
        w_rd_target = r_target[w_l_idx];
        w_rd_ctr    = r_ctr[w_l_idx];
`ifdef BTB_BYPASS_EN
        if (w_wr_en && (w_u_idx == w_l_idx)) begin
            w_rd_valid  = 1'b1;
            w_rd_tag    = w_u_tag;
            w_rd_target = w_new_target;
            w_rd_ctr    = w_new_ctr;
        end
`endif
    end

    assign w_l_hit = i_lookup_valid && !i_flush && w_rd_valid && (w_rd_tag == w_l_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid  <= 1'b0;
            r_hit         <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else begin
            r_resp_valid  <= i_lookup_valid;
            r_hit         <= w_l_hit;
            r_pred_taken  <= w_l_hit && w_rd_ctr[1];
            r_pred_target <= w_l_hit ? w_rd_target : '0;
        end
    end

    assign o_resp_valid  = r_resp_valid;
    assign o_hit         = r_hit;
    assign o_pred_taken  = r_pred_taken;
    assign o_pred_target = r_pred_target;

    // Offset bits and aliased upper PC bits never participate in indexing or tagging.
    logic w_unused_pc_bits;
    assign w_unused_pc_bits = &{1'b0, i_lookup_pc[1:0], i_update_pc[1:0],
                                i_lookup_pc[ADDR_WIDTH-1:INDEX_BITS+TAG_BITS+2],
                                i_update_pc[ADDR_WIDTH-1:INDEX_BITS+TAG_BITS+2]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed scenarios plus random traffic against an entry-level model.
module tb_branch_target_buffer;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_lookup_valid;
    logic [AW-1:0] i_lookup_pc;
    logic          o_resp_valid;
    logic          o_hit;
    logic          o_pred_taken;
    logic [AW-1:0] o_pred_target;
    logic          i_update_valid;
    logic [AW-1:0] i_update_pc;
    logic [AW-1:0] i_update_target;
    logic          i_update_outcome;
    logic          i_update_is_jump;
    logic          i_flush;

    branch_target_buffer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_lookup_valid   (i_lookup_valid),
        .i_lookup_pc      (i_lookup_pc),
        .o_resp_valid     (o_resp_valid),
        .o_hit            (o_hit),
        .o_pred_taken     (o_pred_taken),
        .o_pred_target    (o_pred_target),
        .i_update_valid   (i_update_valid),
        .i_update_pc      (i_update_pc),
        .i_update_target  (i_update_target),
        .i_update_outcome (i_update_outcome),
        .i_update_is_jump (i_update_is_jump),
        .i_flush          (i_flush)
    );

    always #5 clk = ~clk;

    // Reference model: one record per index, counter kept as a plain integer 0..3.
    typedef struct {
        bit          v;
        int          tag;
        logic [31:0] tgt;
        int          ctr;
        bit          jmp;
    } ent_t;

    ent_t          m [64];
    logic [AW+1:0] exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 8) % 1024);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m[i].v = 1'b0;
    endfunction

    function automatic void model_update(input logic [31:0] pc, input logic [31:0] tgt,
                                         input bit taken, input bit jmp);
        int  i;
        bit  hit;
        i   = idx_of(pc);
        hit = m[i].v && (m[i].tag == tag_of(pc));
        if (hit) begin
            if (jmp) begin
                m[i].jmp = 1'b1;
                m[i].ctr = 3;
                m[i].tgt = tgt;
            end else if (m[i].jmp) begin
                if (taken) m[i].tgt = tgt;
            end else if (taken) begin
                m[i].ctr = (m[i].ctr == 3) ? 3 : m[i].ctr + 1;
                m[i].tgt = tgt;
            end else begin
                m[i].ctr = (m[i].ctr == 0) ? 0 : m[i].ctr - 1;
            end
        end else if (taken || jmp) begin
            m[i].v   = 1'b1;
            m[i].tag = tag_of(pc);
            m[i].tgt = tgt;
            m[i].ctr = jmp ? 3 : 2;
            m[i].jmp = jmp;
        end
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, input bit fl);
        int          i;
        bit          hit;
        bit          tk;
        logic [31:0] tg;
        i   = idx_of(pc);
        hit = !fl && m[i].v && (m[i].tag == tag_of(pc));
        tk  = hit && (m[i].ctr >= 2);
        tg  = hit ? m[i].tgt : 32'h0;
        exp_q.push_back({hit, tk, tg});
    endfunction

    task automatic cycle(input bit lv, input logic [31:0] lpc,
                         input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                         input bit uout, input bit ujmp, input bit fl);
        @(negedge clk);
        i_lookup_valid   = lv;
        i_lookup_pc      = lpc;
        i_update_valid   = uv;
        i_update_pc      = upc;
        i_update_target  = utgt;
        i_update_outcome = uout;
        i_update_is_jump = ujmp;
        i_flush          = fl;
`ifdef BTB_BYPASS_EN
        if (uv && !fl) model_update(upc, utgt, uout, ujmp);
        if (lv) model_lookup(lpc, fl);
`else
        if (lv) model_lookup(lpc, fl);
        if (uv && !fl) model_update(upc, utgt, uout, ujmp);
`endif
        if (fl) model_reset();
    endtask

    task automatic lookup(input logic [31:0] pc);
        cycle(1'b1, pc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input bit taken, input bit jmp);
        cycle(1'b0, 32'h0, 1'b1, pc, tgt, taken, jmp, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_outputs_zero(input string name);
        n_vec++;
        if (o_resp_valid !== 1'b0 || o_hit !== 1'b0 || o_pred_taken !== 1'b0 || o_pred_target !== '0) begin
            n_err++;
            $display("FAIL %s: got valid=%b hit=%b taken=%b tgt=%h, want all zero",
                     name, o_resp_valid, o_hit, o_pred_taken, o_pred_target);
        end
    endtask

    // Monitor: pops one expectation per valid response; idle cycles must show zeros.
    always @(posedge clk) begin
        logic [AW+1:0] exp;
        #1;
        if (o_resp_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected: got hit=%b taken=%b tgt=%h, want no response",
                         o_hit, o_pred_taken, o_pred_target);
            end else begin
                exp = exp_q.pop_front();
                if ({o_hit, o_pred_taken, o_pred_target} !== exp) begin
                    n_err++;
                    $display("FAIL resp: got hit=%b taken=%b tgt=%h, want hit=%b taken=%b tgt=%h",
                             o_hit, o_pred_taken, o_pred_target, exp[AW+1], exp[AW], exp[AW-1:0]);
                end
            end
        end else begin
            check_outputs_zero("idle_resp");
        end
    end

    initial begin
        logic [31:0] pc;
        logic [31:0] upc;
        rst_n            = 1'b0;
        i_lookup_valid   = 1'b0;
        i_lookup_pc      = '0;
        i_update_valid   = 1'b0;
        i_update_pc      = '0;
        i_update_target  = '0;
        i_update_outcome = 1'b0;
        i_update_is_jump = 1'b0;
        i_flush          = 1'b0;
        model_reset();
        #1;
        check_outputs_zero("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Cold lookup, allocate, then decay to SN without eviction.
        lookup(32'h0040_0024);
        update(32'h0040_0024, 32'h0040_0100, 1'b1, 1'b0);
        lookup(32'h0040_0024);
        update(32'h0040_0024, 32'h0040_0500, 1'b0, 1'b0);
        update(32'h0040_0024, 32'h0040_0500, 1'b0, 1'b0);
        update(32'h0040_0024, 32'h0040_0500, 1'b0, 1'b0);
        lookup(32'h0040_0024);

        // Same index, different tag overwrites the way.
        update(32'h0040_0124, 32'h0040_0200, 1'b1, 1'b0);
        lookup(32'h0040_0024);
        lookup(32'h0040_0124);

        // Jump stays taken through not-taken feedback.
        update(32'h0040_0040, 32'h0040_1000, 1'b1, 1'b1);
        repeat (3) update(32'h0040_0040, 32'h0040_2000, 1'b0, 1'b0);
        lookup(32'h0040_0040);

        // Miss with NOT_TAKEN does not allocate.
        update(32'h0040_0060, 32'h0040_3000, 1'b0, 1'b0);
        lookup(32'h0040_0060);

        // Same-cycle lookup and update on a cold index.
        cycle(1'b1, 32'h0040_0080, 1'b1, 32'h0040_0080, 32'h0040_0800, 1'b1, 1'b0, 1'b0);
        lookup(32'h0040_0080);

        // Flush beats a concurrent update and lookup.
        cycle(1'b1, 32'h0040_0124, 1'b1, 32'h0040_0124, 32'h0040_0900, 1'b1, 1'b0, 1'b1);
        lookup(32'h0040_0124);
        lookup(32'h0040_0040);

        // Random traffic over a small index/tag pool with aliased upper bits.
        for (int n = 0; n < 1500; n++) begin
            pc  = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 3)) << 8)
                | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            upc = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 3)) << 8)
                | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) upc[9:0] = pc[9:0];
            cycle(bit'($urandom_range(0, 1)), pc,
                  bit'($urandom_range(0, 1)), upc, $urandom,
                  bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 60) == 0));
        end

        // Mid-stream reset: outputs clear at once, pending response dropped, table empty after.
        update(32'h0040_0024, 32'h0040_0100, 1'b1, 1'b0);
        lookup(32'h0040_0024);
        lookup(32'h0040_0024);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_q.delete();
        model_reset();
        i_lookup_valid = 1'b0;
        i_update_valid = 1'b0;
        i_flush        = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lookup(32'h0040_0024);
        lookup(32'h0040_0040);

        repeat (3) idle();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d responses outstanding, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish by time limit, want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Fetch-stage direct-mapped branch target buffer.
- Gives fetch a next-PC guess (hit, taken, target) one cycle after each lookup, before decode runs the gshare direction predictor and the hazard controller computes recovery.
- Trained from the EX-stage branch feedback path, the same path that trains the direction predictor.
- Jumps are held permanently taken.

Parameters:
- ADDR_WIDTH, 32, PC and target width; matches `ADDR_WIDTH.
- INDEX_BITS, 6, log2 of the entry count (64 entries).
- TAG_BITS, 10, stored tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_lookup_valid  in  1  lookup request this cycle
- i_lookup_pc  in  ADDR_WIDTH  fetch PC
- o_resp_valid  out  1  response valid; registered
- o_hit  out  1  tag match with a valid entry
- o_pred_taken  out  1  BranchOutcome, TAKEN=1
- o_pred_target  out  ADDR_WIDTH  predicted target
- i_update_valid  in  1  EX feedback valid (branch or jump resolved)
- i_update_pc  in  ADDR_WIDTH  resolved instruction PC
- i_update_target  in  ADDR_WIDTH  resolved taken target
- i_update_outcome  in  1  TAKEN / NOT_TAKEN
- i_update_is_jump  in  1  unconditional jump
- i_flush  in  1  invalidate all entries

Behaviour:
- Clock and reset: clk; rst_n is asynchronous and active-low, exactly as the codebase names them.
- Address fields:
  - idx = pc[INDEX_BITS+1:2]
  - tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
  - pc[1:0] ignored.
- Entry fields: valid, tag, target, ctr[1:0] (SN=0, WN=1, WT=2, ST=3), jmp.
  - Only the valid bits are reset.
  - Other entry fields are don't-care while valid=0.
- Reset (asynchronous) forces:
  - all valid=0
  - o_resp_valid=0, o_hit=0, o_pred_taken=NOT_TAKEN, o_pred_target=0
- Lookup latency is 1 cycle. A lookup at cycle N produces at N+1:
  - o_resp_valid=1
  - o_hit = valid[idx] & tag match
  - o_pred_taken = o_hit & ctr[1]
  - o_pred_target = o_hit ? stored target : 0
- Idle response: no lookup at N gives o_resp_valid=0 at N+1. o_hit, o_pred_taken and o_pred_target all go to 0.
- Update, on i_update_valid, written at the clock edge:
  - Hit with jmp=1: rewrite the target only; ctr stays ST.
  - Hit with jmp=0: ctr saturates (+1 on TAKEN, −1 on NOT_TAKEN). On TAKEN the target is overwritten with i_update_target.
  - Hit with i_update_is_jump=1: set jmp=1 and ctr=ST.
  - Miss with TAKEN (or jump): allocate and overwrite the way. valid=1 and tag/target are written. Branch: ctr=WT, jmp=0. Jump: ctr=ST, jmp=1.
  - Miss with NOT_TAKEN: no change (no allocation).
  - A counter at SN receiving NOT_TAKEN stays SN; valid stays 1 (no eviction on decay).
- Simultaneous lookup and update, same idx, same cycle: the lookup reads pre-update contents (read-before-write) unless BTB_BYPASS_EN.
- Flush:
  - i_flush at N clears all valid at the N edge.
  - Flush overrides an update in the same cycle; the update is dropped.
  - A lookup in the flush cycle responds at N+1 with o_hit=0, o_pred_taken=0, o_resp_valid=1.
- Reset mid-operation: the pending response is discarded; outputs take their reset values immediately (asynchronously).
- Tag aliasing across the upper PC bits beyond TAG_BITS is permitted. A false hit is recovered by decode/EX through the normal mispredict path.

Optional Feature:
- Macro: BTB_BYPASS_EN.
- Defined: when a lookup and an update hit the same idx in the same cycle, the response reflects the post-update entry (valid, tag, ctr, target, jmp as written this cycle). Flush still wins.
- Undefined: strict read-before-write; no forwarding mux.

Test Plan:
- Reset, then lookup 0x00400024 → next cycle: o_resp_valid=1, o_hit=0, o_pred_taken=0, o_pred_target=0.
- Update pc 0x00400024, target 0x00400100, TAKEN, branch; then lookup the same PC → o_hit=1, o_pred_taken=1, o_pred_target=0x00400100. Two NOT_TAKEN updates (ctr WT→WN→SN) then a lookup → o_hit=1, o_pred_taken=0.
- Alias: after the entry above, update 0x00400124 (idx 0x09, tag 0x001) with TAKEN, target 0x00400200. Lookup 0x00400024 → o_hit=0; lookup 0x00400124 → o_hit=1, target 0x00400200, taken=1.
- Jump: update 0x00400040 (jump, target 0x00401000), then 3× NOT_TAKEN updates → lookup gives o_pred_taken=1, target 0x00401000.
- Same-cycle lookup and update on a cold idx with TAKEN → without macro: o_hit=0; with BTB_BYPASS_EN: o_hit=1, target = update target. In both builds, a lookup the following cycle gives o_hit=1.
- i_flush together with an update and a lookup on a populated entry → response o_hit=0. The next lookup of the same PC also gives o_hit=0 (update dropped). rst_n asserted mid-stream → o_resp_valid=0 immediately, and all entries miss afterwards.
